// File: rtl/dm_arbiter_pkg.sv
// rtl/dm_arbiter_pkg.sv - shared widths, access-type codes and state encoding for the DM arbiter
package dm_arbiter_pkg;

    localparam int STORE_TYPE_SIZE = 2;
    localparam int LOAD_TYPE_SIZE  = 2;
    localparam int DM_SIZE         = 1024;

    localparam logic [STORE_TYPE_SIZE-1:0] ST_WORD = 2'd0;
    localparam logic [STORE_TYPE_SIZE-1:0] ST_HALF = 2'd1;
    localparam logic [STORE_TYPE_SIZE-1:0] ST_BYTE = 2'd2;

    localparam logic [LOAD_TYPE_SIZE-1:0] LD_WORD = 2'd0;
    localparam logic [LOAD_TYPE_SIZE-1:0] LD_HALF = 2'd1;
    localparam logic [LOAD_TYPE_SIZE-1:0] LD_BYTE = 2'd2;

    localparam logic [31:0] DMA_WPC = 32'hFFFF_FFFF;

    typedef enum logic {
        S_IDLE,
        S_D_ACK
    } arb_state_t;

endpackage

// File: rtl/dm_align_chk.sv
// rtl/dm_align_chk.sv - flags misaligned or out-of-range DM accesses
module dm_align_chk
    import dm_arbiter_pkg::*;
#(
    parameter int DM_BYTES = DM_SIZE * 4
) (
    input  logic                       we,
    input  logic [STORE_TYPE_SIZE-1:0] store_type,
    input  logic [LOAD_TYPE_SIZE-1:0]  load_type,
    input  logic [31:0]                addr,
    output logic                       illegal
);

    logic misaligned;

    always_comb begin
        misaligned = 1'b0;
        if (we) begin
            case (store_type)
                ST_WORD: misaligned = (addr[1:0] != 2'b00);
                ST_HALF: misaligned = addr[0];
                default: misaligned = 1'b0;
            endcase
        end else begin
            case (load_type)
                LD_WORD: misaligned = (addr[1:0] != 2'b00);
                LD_HALF: misaligned = addr[0];
                default: misaligned = 1'b0;
            endcase
        end
    end

    assign illegal = misaligned | (addr >= 32'(DM_BYTES));

endmodule

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - shares the data memory between the CPU MEM stage and a DMA/debug master
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 8,
    parameter int DM_BYTES = DM_SIZE * 4
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic                       c_req,
    input  logic                       c_we,
    input  logic [STORE_TYPE_SIZE-1:0] c_store_type,
    input  logic [LOAD_TYPE_SIZE-1:0]  c_load_type,
    input  logic                       c_sign,
    input  logic [31:0]                c_addr,
    input  logic [31:0]                c_wd,
    input  logic [31:0]                c_pc,
    output logic [31:0]                c_rd,
    output logic                       c_stall,
    output logic                       c_err,
    input  logic                       d_req,
    input  logic                       d_we,
    input  logic [STORE_TYPE_SIZE-1:0] d_store_type,
    input  logic [LOAD_TYPE_SIZE-1:0]  d_load_type,
    input  logic                       d_sign,
    input  logic [31:0]                d_addr,
    input  logic [31:0]                d_wd,
    output logic                       d_ack,
    output logic [31:0]                d_rd,
    output logic                       d_err,
    output logic                       dm_memwrite,
    output logic                       dm_memread,
    output logic [STORE_TYPE_SIZE-1:0] dm_store_type,
    output logic [LOAD_TYPE_SIZE-1:0]  dm_load_type,
    output logic                       dm_sign,
    output logic [31:0]                dm_addr,
    output logic [31:0]                dm_wd,
    output logic [31:0]                dm_wpc,
    input  logic [31:0]                dm_rd,
    output logic                       err_sticky,
    output logic                       err_src,
    output logic [31:0]                err_addr
);

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    arb_state_t state_q, state_d;
    logic [7:0] wait_cnt;
    logic       c_illegal, d_illegal;
    logic       c_grant, d_grant;
    logic       sel_we, sel_illegal;

    dm_align_chk #(.DM_BYTES(DM_BYTES)) u_c_chk (
        .we         (c_we),
        .store_type (c_store_type),
        .load_type  (c_load_type),
        .addr       (c_addr),
        .illegal    (c_illegal)
    );

    dm_align_chk #(.DM_BYTES(DM_BYTES)) u_d_chk (
        .we         (d_we),
        .store_type (d_store_type),
        .load_type  (d_load_type),
        .addr       (d_addr),
        .illegal    (d_illegal)
    );

    // D wins only when the CPU is idle or D has starved for MAX_WAIT cycles
    assign d_grant = d_req & (state_q == S_IDLE) & (!c_req | (wait_cnt == MAX_WAIT_C));
    assign c_grant = c_req & !d_grant;
    assign c_stall = c_req & d_grant;
    assign c_err   = c_req & c_illegal;

    assign sel_we      = d_grant ? d_we      : c_we;
    assign sel_illegal = d_grant ? d_illegal : c_illegal;

    assign dm_store_type = d_grant ? d_store_type : c_store_type;
    assign dm_load_type  = d_grant ? d_load_type  : c_load_type;
    assign dm_sign       = d_grant ? d_sign       : c_sign;
    assign dm_addr       = d_grant ? d_addr       : c_addr;
    assign dm_wd         = d_grant ? d_wd         : c_wd;
    assign dm_wpc        = d_grant ? DMA_WPC      : c_pc;

    assign dm_memwrite = (c_grant | d_grant) &  sel_we & !sel_illegal;
    assign dm_memread  = (c_grant | d_grant) & !sel_we & !sel_illegal;

    assign c_rd  = (c_grant & !c_illegal) ? dm_rd : 32'd0;
    assign d_ack = (state_q == S_D_ACK);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (d_grant) state_d = S_D_ACK;
            S_D_ACK: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wait_cnt <= 8'd0;
        end else if (d_grant) begin
            wait_cnt <= 8'd0;
        end else if (d_req && state_q == S_IDLE && wait_cnt < MAX_WAIT_C) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            d_rd  <= 32'd0;
            d_err <= 1'b0;
        end else if (d_grant) begin
            d_rd  <= (!d_we && !d_illegal) ? dm_rd : 32'd0;
            d_err <= d_illegal;
        end
    end

    // First illegal access since reset is kept; later ones are ignored
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            err_sticky <= 1'b0;
            err_src    <= 1'b0;
            err_addr   <= 32'd0;
        end else if (!err_sticky) begin
            if (c_grant && c_illegal) begin
                err_sticky <= 1'b1;
                err_src    <= 1'b0;
                err_addr   <= c_addr;
            end else if (d_grant && d_illegal) begin
                err_sticky <= 1'b1;
                err_src    <= 1'b1;
                err_addr   <= d_addr;
            end
        end
    end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Shares the single-ported data memory (DM) between two requesters: the CPU MEM stage (port C) and a DMA/debug master (port D).
- Port C is single-cycle: access and combinational read in the same cycle, with a stall back to the pipeline when it loses arbitration.
- Port D uses a req/ack handshake with registered read data.
- Also checks alignment and address range, suppresses illegal accesses and keeps a sticky error record.

Parameters:
MAX_WAIT, 8, consecutive cycles port D may be denied before it is force-granted (1..255).
DM_BYTES, `dm_size*4, byte size of DM; any address >= DM_BYTES is out of range.

Ports:
Clock  in  1  system clock, rising edge.
Reset  in  1  asynchronous, active-low reset.
c_req  in  1  CPU MEM stage requests an access this cycle.
c_we  in  1  1 = store, 0 = load.
c_store_type  in  `store_type_size  0 word, 1 half, 2 byte.
c_load_type  in  `load_type_size  0 word, 1 half, 2 byte.
c_sign  in  1  sign-extend a half/byte load.
c_addr  in  32  byte address.
c_wd  in  32  store data.
c_pc  in  32  PC of the access, forwarded for the write display.
c_rd  out  32  load data; combinational, valid when c_req & !c_stall.
c_stall  out  1  CPU must hold its MEM stage this cycle.
c_err  out  1  combinational: current CPU access is illegal.
d_req  in  1  DMA request; fields held stable until d_ack.
d_we, d_store_type, d_load_type, d_sign, d_addr, d_wd  in  as c_*  DMA transaction fields.
d_ack  out  1  one-cycle pulse; transaction complete.
d_rd  out  32  registered load data, valid with d_ack.
d_err  out  1  registered; valid with d_ack; transaction was illegal.
dm_memwrite, dm_memread  out  1  DM strobes.
dm_store_type, dm_load_type, dm_sign, dm_addr, dm_wd  out  as c_*  muxed DM fields.
dm_wpc  out  32  c_pc when CPU granted, 32'hFFFF_FFFF when DMA granted.
dm_rd  in  32  DM read data (combinational).
err_sticky  out  1  any illegal access since reset.
err_src  out  1  source of the first illegal access (0 C, 1 D).
err_addr  out  32  address of the first illegal access.

Behaviour:
- FSM states:
  - IDLE: port D may be granted.
  - D_ACK: cycle after a DMA grant; port D is ineligible this cycle.
- Grant, decided combinationally each cycle; at most one grant per cycle.
  - Only c_req: C.
  - Only d_req, state IDLE: D.
  - Both, state IDLE: D if wait_cnt == MAX_WAIT, else C.
  - Both, state D_ACK: C.
  - Neither: no grant; dm strobes 0; dm_* fields hold port C values.
- c_stall = c_req & grant==D. While stalled, dm_wpc/fields come from D and the C store is not performed.
- wait_cnt, 8-bit:
  - +1 (saturating at MAX_WAIT) each cycle d_req=1, state IDLE and D not granted.
  - Cleared on a D grant.
  - Held in D_ACK.
- On a D grant (rising edge):
  - d_rd <= dm_rd if load, else 0.
  - d_err <= illegal.
  - state <= D_ACK.
  - d_ack asserts next cycle for exactly one cycle.
- D_ACK -> IDLE unconditionally. Port D may reissue d_req in the ack cycle; it is considered from the following cycle.
- Illegal access, decided by dm_align_chk:
  - Word with addr[1:0] != 0, or half with addr[0] = 1, or addr >= DM_BYTES.
  - The granted transaction still completes: D still acks, C is not stalled.
  - dm_memwrite and dm_memread are forced 0.
  - c_rd returns 0.
  - err_sticky, err_src and err_addr are captured only when err_sticky is 0 (first error wins).
- dm_memread = granted & !we & legal; dm_memwrite = granted & we & legal.
- Reset low (async, any time, including mid-handshake): state = IDLE, wait_cnt = 0, d_ack = 0, d_rd = 0, d_err = 0, err_sticky = 0, err_src = 0, err_addr = 0. A D transaction in flight is dropped; port D must reissue it.
- Combinational outputs during reset follow the rules above.

Decomposition:
- Shared header head.v:
  - `store_type_size, `load_type_size, `dm_size.
  - New: `ST_WORD/`ST_HALF/`ST_BYTE = 0/1/2, `LD_WORD/`LD_HALF/`LD_BYTE = 0/1/2, `DMA_WPC = 32'hFFFF_FFFF.
- One sub-module, dm_align_chk (combinational): inputs we, store_type, load_type, addr; output illegal.

Test Plan:
1. Only d_req, store word 0x12345678 at 0x10 -> dm_memwrite high in the grant cycle, d_ack next cycle, d_err 0; a CPU load of 0x10 then returns 0x12345678.
2. c_req and d_req held together continuously, MAX_WAIT=8 -> CPU granted cycles 0-7, c_stall=1 only at cycle 8 (D granted), d_ack at cycle 9, CPU granted again at cycle 9.
3. CPU lh at 0x13 (misaligned) -> c_err 1, dm_memread 0, c_rd 0, err_sticky 1, err_src 0, err_addr 0x13; a later DMA error leaves err_addr at 0x13.
4. DMA sb 0xAB at 0x22 over word 0 -> d_ack, d_err 0; DMA lbu at 0x22 returns d_rd 0x000000AB; lb of 0x80 returns 0xFFFFFF80.
5. DMA request with d_addr = DM_BYTES -> d_ack with d_err 1, no DM write, err_src 1.
6. Reset pulled low in the cycle after a DMA grant, before d_ack -> d_ack never pulses, wait_cnt 0, state IDLE immediately; the DMA request is served after Reset returns high.
